// File: rtl/commit_mon_pkg.sv
// Shared types and constants for the commit trace monitor.
// COMMIT_SEQNUM_EN adds a retire sequence number to every trace record.
package commit_mon_pkg;

   localparam int          REC_XLEN      = 32;
   localparam logic [31:0] SYSCALL_INSTR = 32'h0000000C;
   localparam logic [4:0]  V0_REG        = 5'd2;
   localparam logic [31:0] EXIT_CODE     = 32'hA;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } mon_state_e;

   typedef struct packed {
      logic [REC_XLEN-1:0] pc;
      logic [31:0]         instr;
      logic                wr_en;
      logic [4:0]          wr_reg;
      logic [REC_XLEN-1:0] wr_data;
`ifdef COMMIT_SEQNUM_EN
      logic [31:0]         seq;
`endif
   } commit_rec_t;

endpackage

// File: rtl/commit_fifo.sv
// Trace record FIFO: up to NUM_CH pushes and one pop per cycle; the head is
// read straight out of the storage flops, so a push is visible the next cycle.
module commit_fifo
   import commit_mon_pkg::*;
#(
   parameter  int DEPTH  = 16,
   parameter  int NUM_CH = 1,
   localparam int AW     = $clog2(DEPTH),
   localparam int PW     = AW + 1,
   localparam int CW     = $clog2(NUM_CH + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [CW-1:0] push_cnt,
   input  commit_rec_t push_rec [NUM_CH],
   input  logic        pop,
   output logic        head_valid,
   output commit_rec_t head,
   output logic [PW-1:0] level
);

   commit_rec_t   mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;

   // The extra pointer bit separates full from empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push_cnt);
         rd_ptr <= rd_ptr + PW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_CH; k++)
         if (k < int'(push_cnt))
            mem[wr_ptr[AW-1:0] + AW'(k)] <= push_rec[k];
   end

   assign level      = wr_ptr - rd_ptr;
   assign head_valid = (wr_ptr != rd_ptr);
   assign head       = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/commit_trace_mon.sv
// Retire-trace monitor: buffers retired instructions for a trace sink and
// detects end-of-test (SYSCALL with $v0 == 10). COMMIT_SEQNUM_EN enables out_seq.
module commit_trace_mon
   import commit_mon_pkg::*;
#(
   parameter  int NUM_CH = 1,
   parameter  int DEPTH  = 16,
   parameter  int XLEN   = REC_XLEN,
   localparam int LW     = $clog2(DEPTH) + 1,
   localparam int CW     = $clog2(NUM_CH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_CH-1:0]      ret_valid,
   input  logic [NUM_CH*XLEN-1:0] ret_pc,
   input  logic [NUM_CH*32-1:0]   ret_instr,
   input  logic [NUM_CH-1:0]      ret_wr_en,
   input  logic [NUM_CH*5-1:0]    ret_wr_reg,
   input  logic [NUM_CH*XLEN-1:0] ret_wr_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_pc,
   output logic [31:0]            out_instr,
   output logic                   out_wr_en,
   output logic [4:0]             out_wr_reg,
   output logic [XLEN-1:0]        out_wr_data,
   output logic [31:0]            out_seq,
   output logic [LW-1:0]          fill_level,
   output logic                   overflow,
   output logic                   test_done,
   output logic [1:0]             state
);

   mon_state_e    state_q, state_d;
   logic          run, pop, head_valid, exit_hit, admit, drop;
   commit_rec_t   head;
   commit_rec_t   push_rec [NUM_CH];
   logic [LW-1:0] level;
   logic [CW-1:0] push_cnt;
   logic [XLEN-1:0] v0_q, v0_d;
   logic [NUM_CH-1:0] take;
   int            rank [NUM_CH];
   int            n;
`ifdef COMMIT_SEQNUM_EN
   logic [31:0]   seq_q;
`endif

   // Walk channels oldest first: shadow $v0 evolves in program order and
   // anything after an exiting SYSCALL is discarded.
   always_comb begin
      v0_d     = v0_q;
      exit_hit = 1'b0;
      take     = '0;
      n        = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         rank[i] = n;
         if (run && ret_valid[i] && !exit_hit) begin
            take[i] = 1'b1;
            n       = n + 1;
            if (ret_instr[i*32 +: 32] == SYSCALL_INSTR && v0_d == EXIT_CODE)
               exit_hit = 1'b1;
            else if (ret_wr_en[i] && ret_wr_reg[i*5 +: 5] == V0_REG)
               v0_d = ret_wr_data[i*XLEN +: XLEN];
         end
      end
      // A same-cycle pop frees a slot for this group.
      admit    = (n != 0) && ((DEPTH - int'(level) + int'(pop)) >= n);
      drop     = (n != 0) && !admit;
      push_cnt = admit ? CW'(n) : '0;
   end

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         push_rec[k] = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (take[i] && rank[i] == k) begin
               push_rec[k].pc      = ret_pc[i*XLEN +: XLEN];
               push_rec[k].instr   = ret_instr[i*32 +: 32];
               push_rec[k].wr_en   = ret_wr_en[i];
               push_rec[k].wr_reg  = ret_wr_reg[i*5 +: 5];
               push_rec[k].wr_data = ret_wr_data[i*XLEN +: XLEN];
`ifdef COMMIT_SEQNUM_EN
               push_rec[k].seq     = seq_q + 32'(k);
`endif
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v0_q     <= '0;
         overflow <= 1'b0;
`ifdef COMMIT_SEQNUM_EN
         seq_q    <= '0;
`endif
      end else begin
         v0_q <= v0_d;
         if (drop) overflow <= 1'b1;
`ifdef COMMIT_SEQNUM_EN
         if (admit) seq_q <= seq_q + 32'(n);
`endif
      end
   end

   commit_fifo #(.DEPTH(DEPTH), .NUM_CH(NUM_CH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_cnt   (push_cnt),
      .push_rec   (push_rec),
      .pop        (pop),
      .head_valid (head_valid),
      .head       (head),
      .level      (level)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (exit_hit)    state_d = DRAIN;
         DRAIN:   if (!head_valid) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      run       = (state_q == RUN);
      test_done = (state_q == DONE);
      out_valid = head_valid && (state_q != DONE);
      state     = state_q;
   end

   assign pop         = out_valid && out_ready;
   assign fill_level  = level;
   assign out_pc      = out_valid ? head.pc      : '0;
   assign out_instr   = out_valid ? head.instr   : '0;
   assign out_wr_en   = out_valid ? head.wr_en   : 1'b0;
   assign out_wr_reg  = out_valid ? head.wr_reg  : '0;
   assign out_wr_data = out_valid ? head.wr_data : '0;
`ifdef COMMIT_SEQNUM_EN
   assign out_seq     = out_valid ? head.seq     : '0;
`else
   assign out_seq     = '0;
`endif

endmodule
